vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_DISPLAY, default 640: active pixels per line.
REQ-002 Parameter H_TOTAL, default 800: expected pixel ticks per line.
REQ-003 Parameter H_SYNC_LOAD, default 657: x value loaded on the tick after an hsync rising edge.
REQ-004 Parameter V_DISPLAY, default 480: active lines per frame.
REQ-005 Parameter V_TOTAL, default 525: expected lines per frame.
REQ-006 Parameter V_SYNC_LOAD, default 514: y value loaded on the tick after a vsync rising edge.
REQ-007 Parameter LOCK_FRAMES, default 2: consecutive clean frames required to lock.
REQ-008 clk  input  1  system clock; the only clock.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 p_tick  input  1  pixel enable, one clk wide; all sampling and counting occurs only on clk edges where p_tick=1.
REQ-011 hsync_in  input  1  horizontal sync, high during retrace.
REQ-012 vsync_in  input  1  vertical sync, high during retrace.
REQ-013 x  output  10  recovered pixel column.
REQ-014 y  output  10  recovered line.
REQ-015 video_on  output  1  locked AND x<H_DISPLAY AND y<V_DISPLAY (combinational).
REQ-016 locked  output  1  high in LOCKED state.
REQ-017 frame_start  output  1  one-clk pulse on the tick where x and y wrap to 0 while locked.
REQ-018 sync_err  output  1  one-clk pulse on any timing error detected in ACQUIRE or LOCKED.
REQ-019 h_meas, v_meas  output  10 each  last measured line length (ticks) and frame length (lines).
REQ-020 err_count  output  8  timing error counter (see Configuration).

Function
REQ-021 hsync_in/vsync_in are registered on each tick; a rising edge is current sample 1, previous sample 0.
REQ-022 x and y are flywheel counters: on each tick x increments, wrapping H_TOTAL-1 -> 0; y increments when x wraps, wrapping V_TOTAL-1 -> 0.
REQ-023 On an hsync edge tick, x loads H_SYNC_LOAD instead of incrementing; on a vsync edge tick, y loads V_SYNC_LOAD; both edges on one tick apply both loads.
REQ-024 Line counter counts ticks between hsync edges, saturating at 1023; on each hsync edge its value (including the edge tick) latches into h_meas and the counter restarts at 1.
REQ-025 Frame counter counts hsync edges between vsync edges, saturating at 1023; on each vsync edge it latches into v_meas and restarts at 0.
REQ-026 Line error: hsync edge with line count != H_TOTAL, or line counter reaching 1023 (raised once per saturation).
REQ-027 Frame error: vsync edge with frame count != V_TOTAL, or frame counter reaching 1023.
REQ-028 The first hsync edge after entering ACQUIRE is not checked (no valid reference).
REQ-029 States SEARCH, ACQUIRE, LOCKED; SEARCH -> ACQUIRE on first vsync edge, clearing good-frame count.
REQ-030 ACQUIRE: on each vsync edge, clean frame increments good count, errored frame clears it; good count reaching LOCK_FRAMES -> LOCKED on that tick.
REQ-031 LOCKED: any line or frame error -> SEARCH on that tick; locked falls next clk; sync_err pulses.
REQ-032 sync_err pulses in ACQUIRE and LOCKED only; never in SEARCH.
REQ-033 p_tick=0 holds all state; edges are never detected off-tick.

Reset
REQ-034 Reset asserted: state SEARCH; x, y, h_meas, v_meas, err_count, all counters and sync samples 0; locked, frame_start, sync_err, video_on 0.
REQ-035 Reset asserted mid-frame aborts measurement; after release, lock requires a full SEARCH/ACQUIRE sequence.

Configuration
REQ-036 With VGA_SYNC_RX_ERRCNT_EN defined, err_count increments on each sync_err pulse, saturating at 255, cleared only by reset.
REQ-037 Without VGA_SYNC_RX_ERRCNT_EN, err_count is constant 0 and no counter is implemented.

Verification
REQ-038 Nominal 800x525 sync from the team generator, p_tick every 4 clk -> locked high after third vsync edge, h_meas=800, v_meas=525, no sync_err.
REQ-039 Locked, then one line of 799 ticks -> single sync_err, locked low, state SEARCH, relock after 2 clean frames.
REQ-040 Locked, x/y compared against generator counters for a full frame -> identical, video_on high exactly 640x480 ticks per frame.
REQ-041 hsync_in held low for 1100 ticks while locked -> one sync_err at line count 1023, h_meas unchanged until next edge.
REQ-042 Reset pulsed at y=200 while locked -> all outputs 0 during reset; locked reasserts only after 3 vsync edges.
REQ-043 With VGA_SYNC_RX_ERRCNT_EN, 300 injected errors -> err_count=255; without it, err_count=0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: flywheel x/y recovery, line/frame measurement and a
// SEARCH/ACQUIRE/LOCKED lock tracker. Define VGA_SYNC_RX_ERRCNT_EN for err_count.
module vga_sync_rx #(
  parameter int H_DISPLAY   = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC_LOAD = 657,
  parameter int V_DISPLAY   = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC_LOAD = 514,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_LOAD  = 10'(H_SYNC_LOAD);
  localparam logic [9:0] V_LOAD  = 10'(V_SYNC_LOAD);
  localparam logic [9:0] H_DISP  = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP  = 10'(V_DISPLAY);
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] CNT_PRE = 10'd1022;
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  state_t     state_q;
  logic       hs_q, vs_q, first_h_q, ferr_q, locked_q, fstart_q, serr_q;
  logic [9:0] x_q, y_q, line_q, frame_q, h_meas_q, v_meas_q;
  logic [7:0] good_q;

  logic [9:0] x_d, y_d, line_d, frame_d, f_inc;
  logic       h_edge, v_edge, line_err, frame_err, err, serr_d, wrap;

  always_comb begin
    h_edge    = p_tick & hsync_in & ~hs_q;
    v_edge    = p_tick & vsync_in & ~vs_q;
    x_d       = x_q;
    y_d       = y_q;
    line_d    = line_q;
    frame_d   = frame_q;
    f_inc     = frame_q;
    line_err  = 1'b0;
    frame_err = 1'b0;
    wrap      = 1'b0;
    if (p_tick) begin
      if (h_edge)              x_d = H_LOAD;
      else if (x_q == H_LAST)  x_d = '0;
      else                     x_d = x_q + 10'd1;
      if (v_edge)                          y_d = V_LOAD;
      else if (!h_edge && x_q == H_LAST)   y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      wrap = !h_edge && !v_edge && x_q == H_LAST && y_q == V_LAST;
      // The previous edge tick already counted as 1, so line_q is the full length.
      if (h_edge) begin
        line_d   = 10'd1;
        line_err = (line_q != H_TOT) && !(state_q == ACQUIRE && first_h_q);
      end else if (line_q != CNT_MAX) begin
        line_d   = line_q + 10'd1;
        line_err = (line_q == CNT_PRE);
      end
      if (h_edge && frame_q != CNT_MAX) f_inc = frame_q + 10'd1;
      if (v_edge) begin
        frame_d   = '0;
        frame_err = (f_inc != V_TOT);
      end else begin
        frame_d   = f_inc;
        frame_err = (f_inc == CNT_MAX) && (frame_q != CNT_MAX);
      end
    end
    err    = line_err | frame_err;
    serr_d = err && (state_q != SEARCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      first_h_q <= 1'b0;
      ferr_q    <= 1'b0;
      locked_q  <= 1'b0;
      fstart_q  <= 1'b0;
      serr_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      line_q    <= '0;
      frame_q   <= '0;
      h_meas_q  <= '0;
      v_meas_q  <= '0;
      good_q    <= '0;
    end else begin
      fstart_q <= 1'b0;
      serr_q   <= 1'b0;
      if (p_tick) begin
        hs_q     <= hsync_in;
        vs_q     <= vsync_in;
        x_q      <= x_d;
        y_q      <= y_d;
        line_q   <= line_d;
        frame_q  <= frame_d;
        serr_q   <= serr_d;
        fstart_q <= wrap && (state_q == LOCKED) && !err;
        if (h_edge) begin
          h_meas_q  <= line_q;
          first_h_q <= 1'b0;
        end
        if (v_edge) v_meas_q <= f_inc;
        case (state_q)
          SEARCH: if (v_edge) begin
            state_q   <= ACQUIRE;
            good_q    <= '0;
            ferr_q    <= 1'b0;
            first_h_q <= 1'b1;
          end
          ACQUIRE: begin
            // ferr_q remembers errors earlier in the frame closed by this vsync edge.
            if (v_edge) begin
              ferr_q <= 1'b0;
              if (ferr_q || err) begin
                good_q <= '0;
              end else if (good_q + 8'd1 >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                good_q   <= '0;
              end else begin
                good_q <= good_q + 8'd1;
              end
            end else if (err) begin
              ferr_q <= 1'b1;
            end
          end
          LOCKED: if (err) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] ecnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ecnt_q <= '0;
    else if (serr_d && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
  end
  assign err_count = ecnt_q;
`else
  assign err_count = '0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign locked      = locked_q;
  assign frame_start = fstart_q;
  assign sync_err    = serr_q;
  assign video_on    = locked_q && (x_q < H_DISP) && (y_q < V_DISP);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a scaled 24x12 raster with p_tick every 4 clk.
module tb_vga_sync_rx;
  localparam int HD = 16, HT = 24, HL = 19, VD = 8, VT = 12, VL = 10;
`ifdef VGA_SYNC_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, p_tick = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [9:0] x, y, h_meas, v_meas;
  logic       video_on, locked, frame_start, sync_err;
  logic [7:0] err_count;

  vga_sync_rx #(.H_DISPLAY(HD), .H_TOTAL(HT), .H_SYNC_LOAD(HL), .V_DISPLAY(VD),
                .V_TOTAL(VT), .V_SYNC_LOAD(VL), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .video_on(video_on), .locked(locked), .frame_start(frame_start),
    .sync_err(sync_err), .h_meas(h_meas), .v_meas(v_meas), .err_count(err_count));

  always #5 clk = ~clk;

  typedef enum int {EV_ERR, EV_LOCK, EV_UNLOCK} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic       chk_h;
    logic [9:0] h;
    logic       chk_v;
    logic [9:0] v;
    int         ec;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0, n_bad = 0, exp_errs = 0;
  int   gx = 5, gy = 3, vs_edges = 0;
  logic short_line = 1'b0, force_low = 1'b0, vs_prev = 1'b0, prev_locked = 1'b0;
  logic smp_fs = 1'b0, smp_vo = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int ec_exp(input int n);
    return ERRCNT ? ((n > 255) ? 255 : n) : 0;
  endfunction

  task automatic push_ev(input ev_kind_t k, input logic ch, input int h, input logic cv, input int v);
    ev_t e;
    e.kind = k; e.chk_h = ch; e.h = 10'(h); e.chk_v = cv; e.v = 10'(v); e.ec = ec_exp(exp_errs);
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int h);
    exp_errs++;
    push_ev(EV_ERR, 1'b1, h, 1'b0, 0);
  endtask
  task automatic push_lock();   push_ev(EV_LOCK, 1'b1, HT, 1'b1, VT); endtask
  task automatic push_unlock(); push_ev(EV_UNLOCK, 1'b0, 0, 1'b0, 0); endtask

  task automatic handle(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (e.chk_h) check("event_h_meas", h_meas, e.h);
      if (e.chk_v) check("event_v_meas", v_meas, e.v);
      check("event_err_count", err_count, e.ec);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sync_err)                handle(EV_ERR);
      if (!locked && prev_locked)  handle(EV_UNLOCK);
      if (locked && !prev_locked)  handle(EV_LOCK);
      prev_locked = locked;
    end
  end

  // One pixel tick: inputs change on a negedge, p_tick lasts one clk, 4 clk per tick.
  task automatic step(input logic hs, input logic vs);
    @(negedge clk);
    hsync_in = hs; vsync_in = vs; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0; smp_fs = frame_start; smp_vo = video_on;
    repeat (2) @(negedge clk);
  endtask

  task automatic gen_tick();
    logic hs, vs;
    hs = !force_low && gx >= HL - 1 && gx < HL + 2;
    vs = !force_low && gy >= VL && gy < VL + 2;
    if (vs && !vs_prev) vs_edges++;
    vs_prev = vs;
    step(hs, vs);
    if (gx >= (short_line ? HT - 2 : HT - 1)) begin
      gx = 0; short_line = 1'b0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!locked && n < 6 * HT * VT) begin gen_tick(); n++; end
    check(name, locked, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, bad, von, fs;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {x, y, video_on, locked, frame_start, sync_err, h_meas, v_meas, err_count}, 0);
    reset = 1'b1;

    push_lock();
    wait_lock("lock_initial");

    bad = 0; von = 0; fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      gen_tick();
      if (x != 10'(gx) || y != 10'(gy)) bad++;
      von += int'(smp_vo);
      fs  += int'(smp_fs);
    end
    check("xy_track_mismatches", bad, 0);
    check("video_on_ticks", von, HD * VD);
    check("frame_start_pulses", fs, 1);

    push_err(HT - 1); push_unlock();
    while (gx != 2) gen_tick();
    short_line = 1'b1;
    repeat (2 * HT) gen_tick();
    check("unlocked_after_short_line", locked, 0);
    push_lock();
    wait_lock("relock_short_line");

    push_err(HT); push_unlock();
    force_low = 1'b1; n = 0;
    while (n < 1100 || gx != 0 || gy != 0) begin gen_tick(); n++; end
    check("h_meas_held_while_stuck", h_meas, HT);
    check("unlocked_after_stuck", locked, 0);
    force_low = 1'b0;
    push_lock();
    wait_lock("relock_stuck");

    while (gy != 5 || gx != 2) gen_tick();
    exp_errs = 0; push_unlock();
    reset = 1'b0; bad = 0;
    repeat (4) begin
      gen_tick();
      if ({x, y, video_on, locked, frame_start, sync_err, h_meas, v_meas, err_count} != '0) bad++;
    end
    check("outputs_during_reset", bad, 0);
    reset = 1'b1; vs_edges = 0;
    push_lock();
    wait_lock("relock_after_reset");
    check("vsync_edges_to_lock", vs_edges, 3);

    while (gy != 5) gen_tick();
    exp_errs = 0; push_unlock();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; vs_edges = 0; n = 0;
    while (vs_edges == 0 && n < 2 * HT * VT) begin gen_tick(); n++; end
    check("acquire_entry_edge", vs_edges, 1);
    for (int i = 1; i < 301; i++) push_err(2);
    for (int i = 0; i < 301; i++) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    check("err_count_final", err_count, ec_exp(300));
    check("still_unlocked_in_acquire", locked, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
